// File: rtl/seg7_scan_display.sv
// seg7_scan_display: sequential double-dabble binary-to-BCD converter driving a
// multiplexed active-low seven-segment display with leading-zero blanking.
module seg7_scan_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_WIDTH   = 14,
  parameter int REFRESH_DIV = 50000,
  parameter int LZ_BLANK    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_WIDTH-1:0]  bin_value,
  input  logic                  load,
  output logic                  busy,
  output logic                  overflow,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);
  localparam int BCDW = 4 * (NUM_DIGITS + 1);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = $clog2(REFRESH_DIV);
  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam logic [31:0] MAX_VAL = 32'(10 ** NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                    state;
  logic [BIN_WIDTH-1:0]      val, sh;
  logic [BCDW-1:0]           bcd, adj;
  logic [CW-1:0]             cnt;
  logic [4*NUM_DIGITS-1:0]   disp;
  logic [DW-1:0]             div;
  logic [IW-1:0]             idx;
  logic                      ovf, blank;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 8'h81;
      4'd1: return 8'hCF;
      4'd2: return 8'h92;
      4'd3: return 8'h86;
      4'd4: return 8'hCC;
      4'd5: return 8'hA4;
      4'd6: return 8'hA0;
      4'd7: return 8'h8F;
      4'd8: return 8'h80;
      4'd9: return 8'h84;
      default: return 8'hFF;
    endcase
  endfunction

  for (genvar i = 0; i < NUM_DIGITS + 1; i++) begin : g_adj
    assign adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end

  assign ovf = 32'(val) > MAX_VAL;
  // A digit is a leading zero when it and everything above it is zero.
  assign blank = LZ_BLANK != 0 && idx != '0 && (disp >> {idx, 2'b00}) == '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      overflow <= 1'b0;
      disp     <= '0;
      val      <= '0;
      sh       <= '0;
      bcd      <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          val   <= bin_value;
          sh    <= bin_value;
          bcd   <= '0;
          cnt   <= CW'(BIN_WIDTH);
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          {bcd, sh} <= {adj, sh} << 1;
          cnt       <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= COMMIT;
        end
        COMMIT: begin
          overflow <= ovf;
          disp     <= ovf ? {NUM_DIGITS{4'h9}} : bcd[4*NUM_DIGITS-1:0];
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      idx <= '0;
      an  <= '1;
      seg <= 8'hFF;
    end else begin
      div <= div == DW'(REFRESH_DIV - 1) ? '0 : div + 1'b1;
      if (div == DW'(REFRESH_DIV - 1)) idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
      an  <= ~(NUM_DIGITS'(1) << idx);
      seg <= blank ? 8'hFF : glyph(disp[{idx, 2'b00} +: 4]);
    end
  end
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: scoreboard bench running blanking and non-blanking
// instances side by side with a fast refresh divider.
module tb_seg7_scan_display;
  logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0;
  logic [13:0] bin_value = '0;
  logic        busy_a, busy_b, ovf_a, ovf_b;
  logic [7:0]  seg_a, seg_b;
  logic [3:0]  an_a, an_b;
  int          n_checks = 0, n_fail = 0;

  typedef struct packed {
    logic        ovf;
    logic [31:0] s_lz;
    logic [31:0] s_all;
  } exp_t;
  exp_t q[$];

  seg7_scan_display #(.NUM_DIGITS(4), .BIN_WIDTH(14), .REFRESH_DIV(4), .LZ_BLANK(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bin_value(bin_value), .load(load),
    .busy(busy_a), .overflow(ovf_a), .seg(seg_a), .an(an_a));
  seg7_scan_display #(.NUM_DIGITS(4), .BIN_WIDTH(14), .REFRESH_DIV(4), .LZ_BLANK(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bin_value(bin_value), .load(load),
    .busy(busy_b), .overflow(ovf_b), .seg(seg_b), .an(an_b));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gly(input int d);
    case (d)
      0: return 8'h81; 1: return 8'hCF; 2: return 8'h92; 3: return 8'h86; 4: return 8'hCC;
      5: return 8'hA4; 6: return 8'hA0; 7: return 8'h8F; 8: return 8'h80; 9: return 8'h84;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic exp_t model(input int v);
    exp_t e;
    int v2, p;
    e.ovf = v > 9999;
    v2 = e.ovf ? 9999 : v;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      e.s_all[i*8 +: 8] = gly((v2 / p) % 10);
      e.s_lz[i*8 +: 8]  = (i > 0 && v2 < p) ? 8'hFF : gly((v2 / p) % 10);
      p = p * 10;
    end
    return e;
  endfunction

  task automatic wait_idle(output int n, output bit to);
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    to = n >= 100;
  endtask

  task automatic capture(output logic [31:0] sa, output logic [31:0] sb, output bit to);
    logic [3:0] got;
    got = '0;
    sa = '1;
    sb = '1;
    @(negedge clk);
    for (int c = 0; c < 64 && got != 4'hF; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (an_a === ~(4'b0001 << i)) begin
          sa[i*8 +: 8] = seg_a;
          sb[i*8 +: 8] = seg_b;
          got[i] = 1'b1;
        end
    end
    to = got != 4'hF;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks += 4;
    if (seg_a !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h required ff", seg_a); end
    if (an_a !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %b required 1111", an_a); end
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy_a); end
    if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b required 0", ovf_a); end
  endtask

  task automatic test_scan;
    logic [3:0] ea;
    rst_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      ea = ~(4'b0001 << (((n - 1) / 4) % 4));
      n_checks += 2;
      if (an_a !== ea) begin n_fail++; $display("FAIL scan_an[%0d]: got %b required %b", n, an_a, ea); end
      if (seg_a !== (ea == 4'b1110 ? 8'h81 : 8'hFF)) begin
        n_fail++; $display("FAIL scan_seg[%0d]: got %h required %h", n, seg_a, ea == 4'b1110 ? 8'h81 : 8'hFF);
      end
    end
  endtask

  task automatic check_display(input string name);
    exp_t e;
    logic [31:0] sa, sb;
    bit to;
    n_checks++;
    if (q.size() == 0) begin n_fail++; $display("FAIL %s_queue: got empty required entry", name); return; end
    e = q.pop_front();
    n_checks += 5;
    if (ovf_a !== e.ovf) begin n_fail++; $display("FAIL %s_ovf: got %b required %b", name, ovf_a, e.ovf); end
    if (ovf_b !== e.ovf) begin n_fail++; $display("FAIL %s_ovf_nolz: got %b required %b", name, ovf_b, e.ovf); end
    capture(sa, sb, to);
    if (to) begin n_fail++; $display("FAIL %s_scan_timeout: got incomplete scan required all 4 digits", name); end
    if (sa !== e.s_lz) begin n_fail++; $display("FAIL %s_seg_lz: got %h required %h", name, sa, e.s_lz); end
    if (sb !== e.s_all) begin n_fail++; $display("FAIL %s_seg_nolz: got %h required %h", name, sb, e.s_all); end
  endtask

  task automatic test_convert(input int v);
    int n;
    bit to;
    @(negedge clk);
    bin_value = 14'(v);
    load = 1'b1;
    q.push_back(model(v));
    @(negedge clk);
    load = 1'b0;
    wait_idle(n, to);
    n_checks++;
    if (to || n != 15) begin n_fail++; $display("FAIL conv%0d_busy_cycles: got %0d required 15", v, n); end
    check_display($sformatf("conv%0d", v));
  endtask

  task automatic test_ignored_load;
    int n;
    bit to;
    @(negedge clk);
    bin_value = 14'd1234;
    load = 1'b1;
    q.push_back(model(1234));
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    bin_value = 14'd5678;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_idle(n, to);
    n_checks++;
    if (to || n != 12) begin n_fail++; $display("FAIL ignored_busy_cycles: got %0d required 12", n); end
    check_display("ignored");
    test_convert(5678);
  endtask

  task automatic test_back_to_back;
    int n;
    bit to;
    exp_t e;
    @(negedge clk);
    bin_value = 14'd12000;
    load = 1'b1;
    q.push_back(model(12000));
    @(negedge clk);
    load = 1'b0;
    wait_idle(n, to);
    e = q.pop_front();
    n_checks++;
    if (ovf_a !== e.ovf) begin n_fail++; $display("FAIL b2b_first_ovf: got %b required %b", ovf_a, e.ovf); end
    bin_value = 14'd0;
    load = 1'b1;
    q.push_back(model(0));
    @(negedge clk);
    load = 1'b0;
    n_checks++;
    if (busy_a !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy %b required 1", busy_a); end
    wait_idle(n, to);
    n_checks++;
    if (to || n != 15) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d required 15", n); end
    check_display("b2b");
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bin_value = 14'd4321;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (6) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (seg_a !== 8'hFF) begin n_fail++; $display("FAIL midrst_seg: got %h required ff", seg_a); end
    if (an_a !== 4'hF) begin n_fail++; $display("FAIL midrst_an: got %b required 1111", an_a); end
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b required 0", busy_a); end
    if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL midrst_ovf: got %b required 0", ovf_a); end
    @(negedge clk);
    rst_n = 1'b1;
    q.push_back(model(0));
    check_display("midrst");
    test_convert(4321);
  endtask

  initial begin
    test_reset;
    test_scan;
    test_convert(1234);
    test_convert(7);
    test_convert(12000);
    test_convert(9999);
    test_convert(0);
    test_ignored_load;
    test_back_to_back;
    test_reset_mid;
    n_checks++;
    if (q.size() != 0) begin n_fail++; $display("FAIL queue_drained: got %0d entries required 0", q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
